dct_transpose_buf: RTL and testbench

- Row-to-column transpose stage that sits directly downstream of loeffler_1d in the row-column 2D DCT.
- Collects the serial 12-bit row coefficients of an 8x8 block in row-major order and re-emits them in column-major order.
- Its output feeds the second (column) 1D DCT pass.
- Ping-pong storage with two banks, so the next block can be written while the previous one is read out.

---
 rtl/dct_transpose_buf.sv | 122 ++++++++++++
 tb/tb_dct_transpose_buf.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer between the row and column DCT passes.
// Row-major words are written in; each block is read back column-major. N must be a power of two.
module dct_transpose_buf #(
   parameter int DATA_W = 12,
   parameter int N      = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              out_eoc,
   output logic              out_eob
);
   localparam int DEPTH = N * N;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = $clog2(N);
   localparam logic [AW-1:0] LAST_W = AW'(DEPTH - 1);
   localparam logic [CW-1:0] LAST_C = CW'(N - 1);

   logic [DATA_W-1:0] r_mem [0:2*DEPTH-1];
   logic [1:0]        r_full;
   logic              r_wb;
   logic              r_rb;
   logic [AW-1:0]     r_wc;
   logic [CW-1:0]     r_rrow;
   logic [CW-1:0]     r_rcol;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_eoc;
   logic              r_out_eob;

   logic              w_wr;
   logic              w_ld;
   logic              w_wr_last;
   logic              w_rd_last;
   logic [AW:0]       w_waddr;
   logic [AW:0]       w_raddr;
   logic [1:0]        w_full_set;
   logic [1:0]        w_full_clr;

   // Write/read qualification; a bank is only ever written while empty and read while full
   always_comb begin
      w_wr       = in_valid && !r_full[r_wb];
      w_ld       = (!r_out_valid || out_ready) && r_full[r_rb];
      w_wr_last  = w_wr && (r_wc == LAST_W);
      w_rd_last  = w_ld && (r_rrow == LAST_C) && (r_rcol == LAST_C);
      w_waddr    = {r_wb, r_wc};
      w_raddr    = {r_rb, r_rrow, r_rcol};
      w_full_set = 2'b00;
      w_full_clr = 2'b00;
      if (w_wr_last) begin
         w_full_set[r_wb] = 1'b1;
      end else begin
         w_full_set = 2'b00;
      end
      if (w_rd_last) begin
         w_full_clr[r_rb] = 1'b1;
      end else begin
         w_full_clr = 2'b00;
      end
      in_ready   = !r_full[r_wb];
   end

   // Storage array; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[w_waddr] <= in_data;
      end
   end

   // Bank flags, counters and the output register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_full      <= 2'b00;
         r_wb        <= 1'b0;
         r_rb        <= 1'b0;
         r_wc        <= {AW{1'b0}};
         r_rrow      <= {CW{1'b0}};
         r_rcol      <= {CW{1'b0}};
         r_out_valid <= 1'b0;
         r_out_data  <= {DATA_W{1'b0}};
         r_out_eoc   <= 1'b0;
         r_out_eob   <= 1'b0;
      end else begin
         r_full <= (r_full | w_full_set) & ~w_full_clr;
         if (w_wr) begin
            r_wc <= w_wr_last ? {AW{1'b0}} : r_wc + AW'(1);
            if (w_wr_last) begin
               r_wb <= ~r_wb;
            end
         end
         if (w_ld) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_mem[w_raddr];
            r_out_eoc   <= (r_rrow == LAST_C);
            r_out_eob   <= w_rd_last;
            // Row index runs fastest so each column is emitted contiguously
            if (r_rrow == LAST_C) begin
               r_rrow <= {CW{1'b0}};
               r_rcol <= (r_rcol == LAST_C) ? {CW{1'b0}} : r_rcol + CW'(1);
            end else begin
               r_rrow <= r_rrow + CW'(1);
            end
            if (w_rd_last) begin
               r_rb <= ~r_rb;
            end
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_eoc   = r_out_eoc;
   assign out_eob   = r_out_eob;

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Self-checking bench for dct_transpose_buf: directed vector table plus scoreboarded
// multi-cycle sequences (streaming, backpressure, stalls, resets, input gaps).
module tb_dct_transpose_buf;
   typedef struct {
      logic [11:0] data;
      logic        eoc;
      logic        eob;
   } exp_t;

   typedef struct {
      logic        in_valid;
      logic [11:0] in_data;
      logic        out_ready;
      logic        exp_in_ready;
      logic        exp_out_valid;
      logic [11:0] exp_data;
      logic        exp_eoc;
      logic        exp_eob;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic [11:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [11:0] out_data;
   logic        out_ready;
   logic        out_eoc;
   logic        out_eob;

   int          n_tests = 0;
   int          n_fail = 0;
   int          acc_total = 0;
   int          xfer_cnt = 0;
   int          nacc = 0;
   logic [11:0] blk [64];
   exp_t        exp_q [$];
   vec_t        vecs [129];

   dct_transpose_buf #(.DATA_W(12), .N(8)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .out_eoc   (out_eoc),
      .out_eob   (out_eob)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Reference model: collect a row-major block, queue its column-major readout
   task automatic model_push(input logic [11:0] d);
      exp_t e;
      blk[nacc] = d;
      nacc++;
      if (nacc == 64) begin
         for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) begin
               e.data = blk[r*8+c];
               e.eoc  = (r == 7);
               e.eob  = (r == 7) && (c == 7);
               exp_q.push_back(e);
            end
         end
         nacc = 0;
      end
   endtask

   task automatic clear_model();
      nacc = 0;
      exp_q.delete();
   endtask

   // One clock: observe handshakes before the edge, check results 1 time unit after it
   task automatic step();
      logic        acc, xfer, stall, e_c, b_c;
      logic [11:0] d_c, di;
      exp_t        e;
      acc   = in_valid && in_ready;
      xfer  = out_valid && out_ready;
      stall = out_valid && !out_ready;
      d_c   = out_data;
      e_c   = out_eoc;
      b_c   = out_eob;
      di    = in_data;
      @(posedge clk);
      #1;
      if (acc) begin
         acc_total++;
         model_push(di);
      end
      if (xfer) begin
         xfer_cnt++;
         if (exp_q.size() == 0) begin
            chk("xfer_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("sb_data", 32'(d_c), 32'(e.data));
            chk("sb_eoc", 32'(e_c), 32'(e.eoc));
            chk("sb_eob", 32'(b_c), 32'(e.eob));
         end
      end
      if (stall) begin
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_data", 32'(out_data), 32'(d_c));
         chk("stall_eoc", 32'(out_eoc), 32'(e_c));
         chk("stall_eob", 32'(out_eob), 32'(b_c));
      end
   endtask

   task automatic drain(input string name);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 300 && (exp_q.size() != 0 || out_valid); k++) begin
         step();
      end
      chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
      chk({name, "_idle"}, 32'(out_valid), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({name, "_out_data"}, 32'(out_data), 32'd0);
      chk({name, "_out_eoc"}, 32'(out_eoc), 32'd0);
      chk({name, "_out_eob"}, 32'(out_eob), 32'd0);
   endtask

   initial begin
      int base, xbase, cnt, xd;

      // Single-block vector table: write 0..63, then read back column-major
      for (int t = 0; t < 129; t++) begin
         int j;
         j = t - 64;
         vecs[t].in_valid      = (t < 64);
         vecs[t].in_data       = (t < 64) ? 12'(t) : 12'd0;
         vecs[t].out_ready     = 1'b1;
         vecs[t].exp_in_ready  = 1'b1;
         vecs[t].exp_out_valid = (t >= 64) && (t < 128);
         vecs[t].exp_data      = (t >= 64 && t < 128) ? 12'((j % 8) * 8 + j / 8) : 12'd0;
         vecs[t].exp_eoc       = (t >= 64 && t < 128) && (j % 8 == 7);
         vecs[t].exp_eob       = (t == 127);
      end

      rstn      = 1'b0;
      in_valid  = 1'b0;
      in_data   = 12'd0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rstn = 1'b1;

      for (int t = 0; t < 129; t++) begin
         in_valid  = vecs[t].in_valid;
         in_data   = vecs[t].in_data;
         out_ready = vecs[t].out_ready;
         step();
         chk($sformatf("tbl%0d_in_ready", t), 32'(in_ready), 32'(vecs[t].exp_in_ready));
         chk($sformatf("tbl%0d_out_valid", t), 32'(out_valid), 32'(vecs[t].exp_out_valid));
         if (vecs[t].exp_out_valid) begin
            chk($sformatf("tbl%0d_data", t), 32'(out_data), 32'(vecs[t].exp_data));
            chk($sformatf("tbl%0d_eoc", t), 32'(out_eoc), 32'(vecs[t].exp_eoc));
            chk($sformatf("tbl%0d_eob", t), 32'(out_eob), 32'(vecs[t].exp_eob));
         end
      end
      drain("single");

      // Back-to-back streaming of 4 blocks
      xbase     = xfer_cnt;
      out_ready = 1'b1;
      for (int k = 0; k < 330; k++) begin
         in_valid = (k < 256);
         in_data  = 12'(k);
         if (k < 256) chk("stream_in_ready", 32'(in_ready), 32'd1);
         step();
         xd = xfer_cnt - xbase;
         if (xd > 0 && xd < 256) chk("stream_no_gap", 32'(out_valid), 32'd1);
      end
      chk("stream_count", 32'(xfer_cnt - xbase), 32'd256);
      drain("stream");

      // Backpressure: both banks fill, the 129th word waits
      base      = acc_total;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int k = 0; k < 135; k++) begin
         in_data = 12'(100 + acc_total - base);
         step();
         if (acc_total - base == 128) chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      end
      chk("bp_accepted", 32'(acc_total - base), 32'd128);
      chk("bp_head_valid", 32'(out_valid), 32'd1);
      chk("bp_head_data", 32'(out_data), 32'd100);
      xbase     = xfer_cnt;
      out_ready = 1'b1;
      for (int k = 0; k < 300 && (acc_total - base) < 192; k++) begin
         in_data = 12'(100 + acc_total - base);
         xd = xfer_cnt - xbase;
         if (xd < 63) chk("bp_still_full", 32'(in_ready), 32'd0);
         else if (xd == 63) chk("bp_released", 32'(in_ready), 32'd1);
         step();
      end
      chk("bp_total", 32'(acc_total - base), 32'd192);
      drain("bp");

      // Stall stability under random out_ready
      base     = acc_total;
      in_valid = 1'b1;
      for (int k = 0; k < 400 && (acc_total - base < 64 || exp_q.size() != 0); k++) begin
         in_valid  = (acc_total - base < 64);
         in_data   = 12'(2000 + acc_total - base);
         out_ready = 1'($urandom_range(0, 1));
         step();
      end
      drain("stall");

      // Reset during a partial write, then during a readout
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int k = 0; k < 20; k++) begin
         in_data = 12'(300 + k);
         step();
      end
      #2 rstn = 1'b0;
      #1;
      chk_reset_outputs("rst_wr");
      clear_model();
      #2 rstn = 1'b1;
      out_ready = 1'b0;
      base      = acc_total;
      for (int k = 0; k < 70; k++) begin
         in_valid = (acc_total - base < 64);
         in_data  = 12'(500 + acc_total - base);
         step();
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      for (int k = 0; k < 10; k++) step();
      chk("rst_rd_busy", 32'(out_valid), 32'd1);
      #2 rstn = 1'b0;
      #1;
      chk_reset_outputs("rst_rd");
      clear_model();
      #2 rstn = 1'b1;
      base = acc_total;
      for (int k = 0; k < 64; k++) begin
         in_valid = 1'b1;
         in_data  = 12'h800 + 12'(k);
         step();
      end
      chk("rst_fresh_accepted", 32'(acc_total - base), 32'd64);
      drain("rst_fresh");

      // Random input gaps; latency measured from the 64th accepted word
      base      = acc_total;
      out_ready = 1'b1;
      for (int k = 0; k < 1000 && (acc_total - base) < 64; k++) begin
         in_valid = ($urandom_range(0, 2) != 0);
         in_data  = 12'(777 + acc_total - base);
         step();
      end
      chk("gap_accepted", 32'(acc_total - base), 32'd64);
      chk("gap_lat_k", 32'(out_valid), 32'd0);
      in_valid = 1'b0;
      step();
      chk("gap_lat_k1", 32'(out_valid), 32'd1);
      chk("gap_first", 32'(out_data), 32'd777);
      drain("gap");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
